// File: rtl/clct_busy_window_if.sv
// Bundles the 1st-pass selector result, the registered 1st CLCT and the busy
// window outputs that feed the 2nd-pass selector.
interface clct_busy_window_if #(
    parameter int MXHS    = 224,
    parameter int MXCFEB  = 7,
    parameter int MXKEYBX = 8,
    parameter int MXXKYB  = 10,
    parameter int MXPATB  = 7,
    parameter int MXQLTB  = 6,
    parameter int MXBNDB  = 5,
    parameter int MXPATC  = 12
);
    // best_vld is a one-clock strobe sampled on every rising edge; there is no
    // ready, the block always takes or rejects the candidate in that clock.
    logic                best_vld;
    logic                best_bsy;
    logic [MXKEYBX-1:0]  best_key;
    logic [MXXKYB-1:0]   best_subkey;
    logic [MXPATB-1:0]   best_pat;
    logic [MXQLTB-1:0]   best_qlt;
    logic [MXBNDB-1:0]   best_bend;
    logic [MXPATC-1:0]   best_carry;
    logic [MXQLTB-1:0]   qlt_thresh;

    logic                clct1_vld;
    logic [MXKEYBX-1:0]  clct1_key;
    logic [MXXKYB-1:0]   clct1_subkey;
    logic [MXPATB-1:0]   clct1_pat;
    logic [MXQLTB-1:0]   clct1_qlt;
    logic [MXBNDB-1:0]   clct1_bend;
    logic [MXPATC-1:0]   clct1_carry;
    logic [MXHS-1:0]     busy_mask;
    logic [MXCFEB-1:0]   cfeb_bsy;
    logic                window_active;
    logic [7:0]          rej_cnt;
    logic                state_dbg;

    modport master (
        output best_vld, best_bsy, best_key, best_subkey, best_pat, best_qlt,
               best_bend, best_carry, qlt_thresh,
        input  clct1_vld, clct1_key, clct1_subkey, clct1_pat, clct1_qlt,
               clct1_bend, clct1_carry, busy_mask, cfeb_bsy, window_active,
               rej_cnt, state_dbg
    );

    modport slave (
        input  best_vld, best_bsy, best_key, best_subkey, best_pat, best_qlt,
               best_bend, best_carry, qlt_thresh,
        output clct1_vld, clct1_key, clct1_subkey, clct1_pat, clct1_qlt,
               clct1_bend, clct1_carry, busy_mask, cfeb_bsy, window_active,
               rej_cnt, state_dbg
    );
endinterface

// File: rtl/clct_busy_window.sv
// Captures the 1st-pass CLCT and holds a +/-SPREAD key-HS busy window for HOLD
// clocks so the 2nd-pass search skips the 1st CLCT region.
module clct_busy_window #(
    parameter int MXHS    = 224,
    parameter int MXCFEB  = 7,
    parameter int MXKEYBX = 8,
    parameter int MXXKYB  = 10,
    parameter int MXPATB  = 7,
    parameter int MXQLTB  = 6,
    parameter int MXBNDB  = 5,
    parameter int MXPATC  = 12,
    parameter int SPREAD  = 7,
    parameter int HOLD    = 3
) (
    input logic               clock,
    input logic               reset,
    clct_busy_window_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    localparam logic [3:0]                HOLD_C    = 4'(HOLD);
    localparam logic [MXKEYBX-1:0]        MXHS_K    = MXKEYBX'(MXHS);
    localparam logic signed [MXKEYBX:0]   SPREAD_S  = (MXKEYBX+1)'(SPREAD);
    localparam logic signed [MXKEYBX:0]   HS_LAST_S = (MXKEYBX+1)'(MXHS - 1);

    state_t              state, state_nxt;
    logic [3:0]          hold_cnt, cnt_nxt;
    logic [MXHS-1:0]     mask_q, mask_nxt, mask_calc;
    logic                vld_q;
    logic [MXKEYBX-1:0]  key_q;
    logic [MXXKYB-1:0]   subkey_q;
    logic [MXPATB-1:0]   pat_q;
    logic [MXQLTB-1:0]   qlt_q;
    logic [MXBNDB-1:0]   bend_q;
    logic [MXPATC-1:0]   carry_q;
    logic [7:0]          rej_q;
    logic                window_open, cand_ok, accept, reject;
    logic signed [MXKEYBX:0] key_s, lo_s, hi_s;

    // Last hold clock reopens the window so a new CLCT reloads without a gap.
    assign window_open = (state == S_IDLE) || (hold_cnt == 4'd1);
    assign cand_ok     = !bus.best_bsy && (bus.best_key < MXHS_K) &&
                         (bus.best_qlt >= bus.qlt_thresh);
    assign accept      = bus.best_vld && cand_ok && window_open;
    assign reject      = bus.best_vld && !accept;

    always_comb begin
        key_s = $signed({1'b0, bus.best_key});
        lo_s  = key_s - SPREAD_S;
        hi_s  = key_s + SPREAD_S;
        if (lo_s < 0)         lo_s = '0;
        if (hi_s > HS_LAST_S) hi_s = HS_LAST_S;
        mask_calc = '0;
        for (int i = 0; i < MXHS; i++) begin
            mask_calc[i] = (i >= int'(lo_s)) && (i <= int'(hi_s));
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        mask_nxt  = mask_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_C;
                    mask_nxt  = mask_calc;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    cnt_nxt  = HOLD_C;
                    mask_nxt = mask_calc;
                end else if (hold_cnt == 4'd1) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    mask_nxt  = '0;
                end else begin
                    cnt_nxt = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                mask_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            mask_q   <= '0;
            vld_q    <= 1'b0;
            key_q    <= '0;
            subkey_q <= '0;
            pat_q    <= '0;
            qlt_q    <= '0;
            bend_q   <= '0;
            carry_q  <= '0;
            rej_q    <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= cnt_nxt;
            mask_q   <= mask_nxt;
            vld_q    <= accept;
            if (accept) begin
                key_q    <= bus.best_key;
                subkey_q <= bus.best_subkey;
                pat_q    <= bus.best_pat;
                qlt_q    <= bus.best_qlt;
                bend_q   <= bus.best_bend;
                carry_q  <= bus.best_carry;
            end
            if (reject && (rej_q != 8'hFF)) rej_q <= rej_q + 8'd1;
        end
    end

    always_comb begin
        bus.cfeb_bsy = '0;
        for (int c = 0; c < MXCFEB; c++) begin
            bus.cfeb_bsy[c] = |mask_q[32*c +: 32];
        end
    end

    assign bus.clct1_vld     = vld_q;
    assign bus.clct1_key     = key_q;
    assign bus.clct1_subkey  = subkey_q;
    assign bus.clct1_pat     = pat_q;
    assign bus.clct1_qlt     = qlt_q;
    assign bus.clct1_bend    = bend_q;
    assign bus.clct1_carry   = carry_q;
    assign bus.busy_mask     = mask_q;
    assign bus.window_active = (state == S_HOLD);
    assign bus.rej_cnt       = rej_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_clct_busy_window.sv
// Self-checking bench for clct_busy_window: directed literal cases plus
// randomized candidates compared every clock against a time-based model.
module tb_clct_busy_window;
  localparam int HS = 224;
  localparam int SPREAD = 7;
  localparam int HOLD = 3;

  logic clock;
  logic reset;
  int checks = 0;
  int errors = 0;

  clct_busy_window_if bus ();

  clct_busy_window u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model: last accepted candidate and the edge it was taken on
  int edge_n;
  int last_acc;
  logic m_vld;
  logic [7:0] m_key;
  logic [9:0] m_subkey;
  logic [6:0] m_pat;
  logic [5:0] m_qlt;
  logic [4:0] m_bend;
  logic [11:0] m_carry;
  int m_rej;
  logic [7:0] exp_q[$];

  function automatic logic [HS-1:0] window_of(input int key);
    logic [HS-1:0] m;
    m = '0;
    for (int i = 0; i < HS; i++) if (i >= key - SPREAD && i <= key + SPREAD) m[i] = 1'b1;
    return m;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_n = 0; last_acc = -100; m_vld = 1'b0; m_rej = 0;
      m_key = '0; m_subkey = '0; m_pat = '0; m_qlt = '0; m_bend = '0; m_carry = '0;
      exp_q.delete();
    end else begin
      edge_n++;
      m_vld = 1'b0;
      if (bus.best_vld) begin
        if (!bus.best_bsy && int'(bus.best_key) < HS && bus.best_qlt >= bus.qlt_thresh &&
            edge_n - last_acc >= HOLD) begin
          last_acc = edge_n;
          m_vld = 1'b1;
          m_key = bus.best_key; m_subkey = bus.best_subkey; m_pat = bus.best_pat;
          m_qlt = bus.best_qlt; m_bend = bus.best_bend; m_carry = bus.best_carry;
          exp_q.push_back(bus.best_key);
        end else if (m_rej < 255) begin
          m_rej++;
        end
      end
    end
  end

  // ---------------- checker
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [HS-1:0] em;
    logic [6:0] ec;
    logic [7:0] k;
    if (!reset) begin
      em = (edge_n - last_acc < HOLD) ? window_of(int'(m_key)) : '0;
      ec = '0;
      for (int c = 0; c < 7; c++) ec[c] = |em[32*c +: 32];
      chk("vld", 256'(bus.clct1_vld), 256'(m_vld));
      chk("mask", 256'(bus.busy_mask), 256'(em));
      chk("cfeb", 256'(bus.cfeb_bsy), 256'(ec));
      chk("window", 256'(bus.window_active), 256'(em != '0));
      chk("rej", 256'(bus.rej_cnt), 256'(m_rej));
      chk("fields", {bus.clct1_key, bus.clct1_subkey, bus.clct1_pat, bus.clct1_qlt,
                     bus.clct1_bend, bus.clct1_carry},
                    {m_key, m_subkey, m_pat, m_qlt, m_bend, m_carry});
      if (bus.clct1_vld) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 256'(1), 256'(0));
        end else begin
          k = exp_q.pop_front();
          chk("sb_key", 256'(bus.clct1_key), 256'(k));
        end
      end
    end
  end

  // ---------------- drivers
  task automatic drive(input logic bsy, input logic [7:0] key, input logic [5:0] qlt);
    bus.best_vld = 1'b1; bus.best_bsy = bsy; bus.best_key = key; bus.best_qlt = qlt;
    bus.best_subkey = 10'($urandom); bus.best_pat = 7'($urandom);
    bus.best_bend = 5'($urandom); bus.best_carry = 12'($urandom);
    @(posedge clock); #1;
    bus.best_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [HS-1:0] lit(input int nbits, input int lsb);
    logic [HS-1:0] one;
    one = 1;
    return ((one << nbits) - one) << lsb;
  endfunction

  // ---------------- stimulus
  initial begin
    bus.best_vld = 0; bus.best_bsy = 0; bus.best_key = 0; bus.best_subkey = 0;
    bus.best_pat = 0; bus.best_qlt = 0; bus.best_bend = 0; bus.best_carry = 0;
    bus.qlt_thresh = 6'd10;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_mask", 256'(bus.busy_mask), 256'(0));
    chk("rst_rej", 256'(bus.rej_cnt), 256'(0));

    // range check
    drive(0, 8'd100, 6'd20);
    chk("r_vld", 256'(bus.clct1_vld), 256'(1));
    chk("r_key", 256'(bus.clct1_key), 256'(100));
    chk("r_mask", 256'(bus.busy_mask), 256'(lit(15, 93)));
    chk("r_cfeb", 256'(bus.cfeb_bsy), 256'(7'b0001100));
    chk("r_win", 256'(bus.window_active), 256'(1));
    idle(2);
    chk("r_mask3", 256'(bus.busy_mask), 256'(lit(15, 93)));
    idle(1);
    chk("r_mask_off", 256'(bus.busy_mask), 256'(0));
    chk("r_win_off", 256'(bus.window_active), 256'(0));

    // edge clipping
    drive(0, 8'd2, 6'd20);
    chk("lo_mask", 256'(bus.busy_mask), 256'(lit(10, 0)));
    chk("lo_cfeb", 256'(bus.cfeb_bsy), 256'(7'b0000001));
    idle(3);
    drive(0, 8'd223, 6'd20);
    chk("hi_mask", 256'(bus.busy_mask), 256'(lit(8, 216)));
    chk("hi_cfeb", 256'(bus.cfeb_bsy), 256'(7'b1000000));
    idle(3);

    // rejects
    drive(0, 8'd255, 6'd20);
    chk("rj_key", 256'({bus.rej_cnt, bus.clct1_vld, bus.busy_mask}), 256'({8'd1, 1'b0, 224'd0}));
    drive(0, 8'd100, 6'd5);
    chk("rj_qlt", 256'({bus.rej_cnt, bus.clct1_vld, bus.busy_mask}), 256'({8'd2, 1'b0, 224'd0}));
    drive(1, 8'd100, 6'd20);
    chk("rj_bsy", 256'({bus.rej_cnt, bus.clct1_vld, bus.busy_mask}), 256'({8'd3, 1'b0, 224'd0}));

    // retrigger timing
    drive(0, 8'd50, 6'd20);
    drive(0, 8'd150, 6'd20);
    chk("rt_rej", 256'(bus.rej_cnt), 256'(4));
    chk("rt_keep", 256'(bus.busy_mask), 256'(lit(15, 43)));
    idle(1);
    chk("rt_keep2", 256'(bus.busy_mask), 256'(lit(15, 43)));
    drive(0, 8'd150, 6'd20);
    chk("rt_vld", 256'(bus.clct1_vld), 256'(1));
    chk("rt_mask", 256'(bus.busy_mask), 256'(lit(15, 143)));
    idle(2);
    chk("rt_win", 256'(bus.window_active), 256'(1));
    idle(1);
    chk("rt_win_off", 256'(bus.window_active), 256'(0));

    // saturation
    for (int i = 0; i < 300; i++) drive(1, 8'($urandom_range(0, 223)), 6'd20);
    chk("sat", 256'(bus.rej_cnt), 256'(255));

    // reset mid-HOLD
    drive(0, 8'd60, 6'd20);
    idle(1);
    #4 reset = 1'b1;
    #1;
    chk("ar_mask", 256'({bus.busy_mask, bus.cfeb_bsy}), 256'(0));
    chk("ar_clct", 256'({bus.clct1_key, bus.clct1_qlt, bus.rej_cnt, bus.window_active}), 256'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, 8'd80, 6'd20);
    chk("ar_next", 256'({bus.clct1_vld, bus.clct1_key}), 256'({1'b1, 8'd80}));

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bus.qlt_thresh = 6'($urandom_range(0, 40));
      bus.best_vld = ($urandom_range(0, 99) < 55);
      bus.best_bsy = ($urandom_range(0, 99) < 10);
      bus.best_key = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(224, 255))
                                                 : 8'($urandom_range(0, 223));
      bus.best_qlt = 6'($urandom); bus.best_subkey = 10'($urandom);
      bus.best_pat = 7'($urandom); bus.best_bend = 5'($urandom);
      bus.best_carry = 12'($urandom);
      @(posedge clock); #1;
    end
    bus.best_vld = 1'b0;
    idle(HOLD + 2);
    chk("sb_drain", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clct_busy_window.md
Name: clct_busy_window

Overview:
- Sits directly downstream of the 1st-pass best-of-CFEB CLCT selector.
- Registers the winning 1st CLCT and builds a key-half-strip busy mask of ±SPREAD around its key.
- Holds that mask for HOLD clocks and drives per-CFEB busy flags into the 2nd-pass selector, so the 2nd CLCT search excludes the 1st CLCT region.
- Counts rejected 1st-pass candidates for monitoring.

Parameters:
- MXHS, 224: key half-strips per chamber (7 CFEBs × 32).
- MXCFEB, 7: CFEBs; CFEB i covers HS 32i..32i+31.
- MXKEYBX, 8: key width.
- MXXKYB, 10: 1/8-strip subkey width.
- MXPATB, 7: pattern width.
- MXQLTB, 6: quality width.
- MXBNDB, 5: bend width.
- MXPATC, 12: comparator-code width.
- SPREAD, 7: busy half-width in HS.
- HOLD, 3: busy duration in clocks; legal values 1..15.

Ports:
- clock, input, 1: 40 MHz LHC clock.
- reset, input, 1: asynchronous, active-high.
- best_vld, input, 1: 1st-pass selector output valid strobe.
- best_bsy, input, 1: selector found nothing (all CFEBs busy).
- best_key, input, MXKEYBX: selected key half-strip.
- best_subkey, input, MXXKYB: selected 1/8-strip key.
- best_pat, input, MXPATB: selected pattern.
- best_qlt, input, MXQLTB: selected quality.
- best_bend, input, MXBNDB: selected bend.
- best_carry, input, MXPATC: selected comparator code.
- qlt_thresh, input, MXQLTB: minimum accepted quality.
- clct1_vld, output, 1: one-clock pulse, 1st CLCT captured.
- clct1_key, output, MXKEYBX: registered 1st CLCT key.
- clct1_subkey, output, MXXKYB: registered 1st CLCT subkey.
- clct1_pat, output, MXPATB: registered 1st CLCT pattern.
- clct1_qlt, output, MXQLTB: registered 1st CLCT quality.
- clct1_bend, output, MXBNDB: registered 1st CLCT bend.
- clct1_carry, output, MXPATC: registered 1st CLCT comparator code.
- busy_mask, output, MXHS: per-key-HS busy for the 2nd pass.
- cfeb_bsy, output, MXCFEB: OR of busy_mask over each CFEB's 32 HS.
- window_active, output, 1: high in HOLD state.
- rej_cnt, output, 8: saturating count of rejected candidates.

Behaviour:
- Reset (async, active-high): every output 0; state IDLE; hold counter 0. Reset mid-HOLD clears the mask on assertion, not at the next clock edge.
- Candidate: cycle with best_vld=1.
  - Accept iff best_bsy=0, best_key<MXHS, best_qlt>=qlt_thresh, and the accept window is open.
  - Accept window is open in IDLE, or in HOLD when hold counter==1 (last hold cycle: seamless reload, no dead clock).
- Reject: any candidate failing the accept test increments rej_cnt by 1, saturating at 255.
  - best_key>=MXHS (wrapped offset arithmetic, e.g. 254/255) is rejected even when quality passes.
  - best_vld=0 never counts.
- Latency: candidate accepted at edge N.
  - At N+1: clct1_* registered, clct1_vld=1 for exactly one clock.
  - At N+1: busy_mask loaded, hold counter=HOLD, state=HOLD.
- Mask arithmetic: bits max(0, key−SPREAD)..min(MXHS−1, key+SPREAD) set; all others 0.
  - Compute in MXKEYBX+1-bit signed arithmetic.
  - Clip at chamber edges; no wrap-around.
- cfeb_bsy[i] = |busy_mask[32i+31:32i]. Combinational from the registered mask, so it is aligned with busy_mask.
- State machine:
  - IDLE→HOLD on accept.
  - In HOLD, the counter decrements each clock. HOLD→IDLE when the counter reaches 1 with no accept.
  - On that transition, busy_mask, cfeb_bsy and window_active clear at the same edge.
  - HOLD→HOLD on an accept at counter==1: mask and clct1_* reload, counter=HOLD.
- Busy duration: busy_mask is nonzero for exactly HOLD consecutive clocks per accept.
- clct1_* hold their last value until the next accept; only clct1_vld pulses.
- No back-pressure to the upstream selector.
- Rejected candidates never alter clct1_* or busy_mask.

Test Plan:
- Range check: key=100, qlt=20, thresh=10, SPREAD=7, HOLD=3, accepted at edge N.
  - N+1: clct1_vld=1, clct1_key=100, mask bits 93..107 set, cfeb_bsy=7'b0001100, window_active=1.
  - Mask high for N+1..N+3; all-zero at N+4.
- Edge clipping:
  - key=2 → mask bits 0..9, cfeb_bsy=7'b0000001.
  - key=223 → bits 216..223, cfeb_bsy=7'b1000000.
  - No bit outside [0,223].
- Rejects:
  - key=255 → rejected, rej_cnt 0→1.
  - qlt=5 with thresh=10 → rej_cnt=2.
  - best_bsy=1 → rej_cnt=3.
  - In all three cases clct1_vld stays 0 and busy_mask stays 0.
- Retrigger timing:
  - Accept key=50 at N; candidate key=150 at N+1 (counter=3) → rejected, rej_cnt+1.
  - Candidate key=150 at N+3 (counter=1) → accepted, mask moves to 143..157 at N+4 with no zero clock, window held through N+6.
- Saturation: 300 consecutive rejected candidates → rej_cnt stops at 255.
- Reset mid-HOLD: assert reset at N+2 between clock edges → busy_mask, cfeb_bsy, clct1_*, rej_cnt go to 0 immediately; after release, the next valid candidate is accepted normally.
